// File: rtl/pm_arbiter_pkg.sv
// Shared types and default sizing for the program-memory fetch arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pm_arbiter_pkg;

    localparam int PM_ADDR_W  = 8;
    localparam int PM_DATA_W  = 8;
    localparam int PM_MEM_LAT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/pm_arbiter_rr.sv
// Two-way round-robin pick between cache 0 and cache 1 fetch requests.
// Latency: purely combinational.
// Backpressure: none; the caller only consults grant while a request is present.
module pm_arbiter_rr (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant
);

    // grant is the winning requester id: on a tie the one not served last wins
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/pm_arbiter.sv
// Arbitrates two instruction-cache fetch ports onto one fixed-latency program memory.
// Latency: request sampled at edge T returns ack/rdata in the cycle after edge T+MEM_LAT.
// Backpressure: hold_x stalls a requester until its ack; PM_ARBITER_STATS_EN adds stall counters.
module pm_arbiter
    import pm_arbiter_pkg::*;
#(
    parameter int ADDR_W  = PM_ADDR_W,
    parameter int DATA_W  = PM_DATA_W,
    parameter int MEM_LAT = PM_MEM_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              hold0,
    output logic              hold1,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        hold_count,
    output logic              start_hold,
    output logic              end_hold,
    output logic [15:0]       stall0,
    output logic [15:0]       stall1
);

    localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

    state_t state;
    logic   gnt;        // requester owning the current access
    logic   rr_ptr;     // requester favoured on the next tie (0 after reset)
    logic   rr_grant;
    logic   last_srv;

    assign last_srv = ~rr_ptr;

    pm_arbiter_rr u_rr (
        .req0  (req0),
        .req1  (req1),
        .last  (last_srv),
        .grant (rr_grant)
    );

    // A requester is stalled whenever it asks and is not being answered this cycle
    assign hold0 = req0 & ~ack0;
    assign hold1 = req1 & ~ack1;

    // Access sequencer: latch grantee in IDLE, count memory latency, pulse ack in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            rr_ptr     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            hold_count <= '0;
            start_hold <= 1'b0;
            end_hold   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= '0;
        end else begin
            start_hold <= 1'b0;
            end_hold   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt        <= rr_grant;
                        mem_addr   <= rr_grant ? addr1 : addr0;
                        mem_rd     <= 1'b1;
                        hold_count <= '0;
                        start_hold <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // the access always completes, even if the requester has let go
                    if (hold_count == LAST_CNT) begin
                        rdata      <= mem_rdata;
                        mem_rd     <= 1'b0;
                        hold_count <= '0;
                        ack0       <= ~gnt;
                        ack1       <= gnt;
                        end_hold   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        hold_count <= hold_count + 3'd1;
                    end
                end
                DONE: begin
                    rr_ptr <= ~gnt;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PM_ARBITER_STATS_EN
    // Saturating count of cycles each requester spends held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall0 <= '0;
            stall1 <= '0;
        end else begin
            if (hold0 && (stall0 != 16'hFFFF)) begin
                stall0 <= stall0 + 16'd1;
            end
            if (hold1 && (stall1 != 16'hFFFF)) begin
                stall1 <= stall1 + 16'd1;
            end
        end
    end
`else
    assign stall0 = '0;
    assign stall1 = '0;
`endif

endmodule

// File: tb/tb_pm_arbiter.sv
// Self-checking bench for pm_arbiter: directed scenarios plus randomized traffic.
// Latency: model tracks elapsed cycles since each grant.
// Backpressure: requesters hold req until they observe their ack.
module tb_pm_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata;
    logic          hold0, hold1;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    hold_count;
    logic          start_hold, end_hold;
    logic [15:0]   stall0, stall1;

    logic [DW-1:0] mem [256];

    int checks = 0;
    int errors = 0;

    // behavioural model: an access is "busy" for LAT cycles plus one answer cycle
    bit            m_busy  = 1'b0;
    int            m_t     = 0;
    bit            m_gnt   = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    bit            m_ptr   = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    int            m_st0   = 0;
    int            m_st1   = 0;

    bit seen0 = 1'b0;
    bit seen1 = 1'b0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_rd ? mem[mem_addr] : '0;

    pm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .addr0      (addr0),
        .addr1      (addr1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata      (rdata),
        .hold0      (hold0),
        .hold1      (hold1),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .hold_count (hold_count),
        .start_hold (start_hold),
        .end_hold   (end_hold),
        .stall0     (stall0),
        .stall1     (stall1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_ack(input int x);
        return m_busy && (m_t == LAT) && (int'(m_gnt) == x);
    endfunction

    // Reference model advances on each edge from the requests it sees
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy  = 1'b0;
            m_t     = 0;
            m_gnt   = 1'b0;
            m_addr  = '0;
            m_ptr   = 1'b0;
            m_rdata = '0;
            m_st0   = 0;
            m_st1   = 0;
        end else begin
            if (req0 && !exp_ack(0) && m_st0 < 65535) m_st0++;
            if (req1 && !exp_ack(1) && m_st1 < 65535) m_st1++;
            if (m_busy) begin
                if (m_t == LAT) begin
                    m_busy = 1'b0;
                    m_ptr  = !m_gnt;
                    m_t    = 0;
                end else begin
                    if (m_t == LAT - 1) m_rdata = mem[m_addr];
                    m_t++;
                end
            end else if (req0 || req1) begin
                m_gnt  = (req0 && req1) ? m_ptr : req1;
                m_addr = m_gnt ? addr1 : addr0;
                m_busy = 1'b1;
                m_t    = 0;
            end
        end
    end

    // Compare every output against the model once per cycle, away from the edge
    always @(negedge clk) begin
        bit e_rd, e_a0, e_a1;
        e_rd = m_busy && (m_t < LAT);
        e_a0 = exp_ack(0);
        e_a1 = exp_ack(1);
        chk("mem_rd", 32'(mem_rd), 32'(e_rd));
        if (e_rd) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("hold_count", 32'(hold_count), e_rd ? 32'(m_t) : 32'd0);
        chk("start_hold", 32'(start_hold), 32'(m_busy && m_t == 0));
        chk("end_hold", 32'(end_hold), 32'(m_busy && m_t == LAT));
        chk("ack0", 32'(ack0), 32'(e_a0));
        chk("ack1", 32'(ack1), 32'(e_a1));
        chk("hold0", 32'(hold0), 32'(req0 && !e_a0));
        chk("hold1", 32'(hold1), 32'(req1 && !e_a1));
        chk("rdata", 32'(rdata), 32'(m_rdata));
`ifdef PM_ARBITER_STATS_EN
        chk("stall0", 32'(stall0), 32'(m_st0));
        chk("stall1", 32'(stall1), 32'(m_st1));
`else
        chk("stall0", 32'(stall0), 32'd0);
        chk("stall1", 32'(stall1), 32'd0);
`endif
        seen0 = ack0;
        seen1 = ack1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Wait (bounded) for the next ack; n counts falling edges from the call
    task automatic wait_ack(output int who, output int n, output int rd10);
        who  = -1;
        n    = 0;
        rd10 = 0;
        while (who < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (mem_rd && mem_addr == 8'h10) rd10++;
            if (ack0) who = 0;
            else if (ack1) who = 1;
        end
    endtask

    initial begin
        int w, n, rd;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hA5;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_hold_count", 32'(hold_count), 32'd0);
        chk("reset_mem_rd", 32'(mem_rd), 32'd0);
        chk("reset_stall1", 32'(stall1), 32'd0);
        tick();
        reset = 1'b1;

        // single fetch: ack after LAT access cycles, data from address 0x10
        tick();
        req0 = 1'b1; addr0 = 8'h10;
        wait_ack(w, n, rd);
        chk("single_who", 32'(w), 32'd0);
        chk("single_latency", 32'(n), 32'd6);
        chk("single_addr_cycles", 32'(rd), 32'd4);
        chk("single_rdata", 32'(rdata), 32'hA5);
        tick();
        req0 = 1'b0;

        // contention from a fresh reset: 0 first, then 1; stall1 = 11
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'h20; addr1 = 8'h30;
        wait_ack(w, n, rd);
        chk("contend_first", 32'(w), 32'd0);
        tick();
        req0 = 1'b0;
        wait_ack(w, n, rd);
        chk("contend_second", 32'(w), 32'd1);
        chk("contend_rdata", 32'(rdata), 32'(mem[8'h30]));
`ifdef PM_ARBITER_STATS_EN
        chk("contend_stall1", 32'(stall1), 32'd11);
`else
        chk("contend_stall1", 32'(stall1), 32'd0);
`endif
        tick();
        req1 = 1'b0;

        // cache 0 re-requests at once while cache 1 waits: the collision goes to 1
        tick();
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'h21; addr1 = 8'h31;
        wait_ack(w, n, rd);
        chk("collide_a", 32'(w), 32'd0);
        tick();
        wait_ack(w, n, rd);
        chk("collide_b", 32'(w), 32'd1);
        tick();
        req1 = 1'b0;
        wait_ack(w, n, rd);
        chk("collide_c", 32'(w), 32'd0);
        tick();
        req0 = 1'b0;

        // late request during an access does not preempt it
        tick();
        req0 = 1'b1; addr0 = 8'h40;
        tick();
        tick();
        req1 = 1'b1; addr1 = 8'h50;
        wait_ack(w, n, rd);
        chk("late_first", 32'(w), 32'd0);
        tick();
        req0 = 1'b0;
        wait_ack(w, n, rd);
        chk("late_second", 32'(w), 32'd1);
        tick();
        req1 = 1'b0;

        // reset in the second access cycle abandons the fetch
        tick();
        req0 = 1'b1; addr0 = 8'h60;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("abort_hold_count", 32'(hold_count), 32'd0);
        chk("abort_ack0", 32'(ack0), 32'd0);
        chk("abort_mem_rd", 32'(mem_rd), 32'd0);
        tick();
        reset = 1'b1;
        wait_ack(w, n, rd);
        chk("abort_retry_who", 32'(w), 32'd0);
        chk("abort_retry_latency", 32'(n), 32'd6);
        chk("abort_retry_rdata", 32'(rdata), 32'(mem[8'h60]));
        tick();
        req0 = 1'b0;

        // requester 0 gives up mid-access: ack still pulses, then 1 is served
        tick();
        req0 = 1'b1; addr0 = 8'h70;
        tick();
        req1 = 1'b1; addr1 = 8'h71;
        tick();
        tick();
        req0 = 1'b0;
        wait_ack(w, n, rd);
        chk("drop_ack0", 32'(w), 32'd0);
        tick();
        wait_ack(w, n, rd);
        chk("drop_next", 32'(w), 32'd1);
        tick();
        req1 = 1'b0;

        // randomized traffic with occasional drops and resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 599) != 0);
            if (req0) begin
                if (seen0) begin
                    req0  = ($urandom_range(0, 3) == 0);
                    addr0 = 8'($urandom);
                end else if ($urandom_range(0, 39) == 0) begin
                    req0 = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                req0  = 1'b1;
                addr0 = 8'($urandom);
            end
            if (req1) begin
                if (seen1) begin
                    req1  = ($urandom_range(0, 3) == 0);
                    addr1 = 8'($urandom);
                end else if ($urandom_range(0, 39) == 0) begin
                    req1 = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                req1  = 1'b1;
                addr1 = 8'($urandom);
            end
        end
        tick();
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pm_arbiter.md
PM_ARBITER -- requirements
Module: pm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the program-memory address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the instruction/data width.
REQ-003 Parameter MEM_LAT, default 4, legal 1..7, SHALL set the shared memory read latency in cycles.
REQ-004 clk  in  1  single clock; all state on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req0, req1  in  1  fetch request from cache 0 / cache 1, held until the matching ack.
REQ-007 addr0, addr1  in  ADDR_W  fetch address, stable while req is high.
REQ-008 ack0, ack1  out  1  one-cycle pulse; rdata is valid in that cycle.
REQ-009 rdata  out  DATA_W  returned word, shared by both requesters.
REQ-010 hold0, hold1  out  1  stall to the requesting core.
REQ-011 mem_rd  out  1 / mem_addr  out  ADDR_W / mem_rdata  in  DATA_W  shared memory port.
REQ-012 hold_count  out  3 / start_hold  out  1 / end_hold  out  1  access progress and event pulses.
REQ-013 stall0, stall1  out  16  per-requester stall-cycle counters (see Configuration).

Function
REQ-014 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-015 IDLE with any req high: the FSM SHALL latch the grantee and its address and enter ACCESS on the next edge.
REQ-016 Both req high in IDLE: the FSM SHALL grant the requester not served last; the pointer favours 0 after reset.
REQ-017 ACCESS: mem_rd SHALL be 1 and mem_addr SHALL be the latched address; hold_count SHALL count 0..MEM_LAT-1.
REQ-018 At hold_count==MEM_LAT-1, rdata SHALL capture mem_rdata and the FSM SHALL enter DONE.
REQ-019 DONE: the grantee's ack SHALL pulse and end_hold SHALL pulse for exactly one cycle; the pointer SHALL update; next state SHALL be IDLE.
REQ-020 start_hold SHALL pulse in the first ACCESS cycle only.
REQ-021 Latency: req sampled at edge T SHALL yield ack in cycle T+MEM_LAT+1.
REQ-022 hold_x SHALL be combinational req_x AND NOT ack_x, so a waiting requester is also held while the other is served.
REQ-023 A req that drops mid-access SHALL NOT abort the access; the ack SHALL still pulse and the result is discarded.
REQ-024 A new req arriving during ACCESS/DONE SHALL wait for IDLE; it SHALL never preempt an access.
REQ-025 hold_count SHALL read 0 outside ACCESS; mem_rd and ack SHALL be 0 outside their states.

Reset
REQ-026 reset low SHALL force IDLE, rdata=0, hold_count=0, all pulses/mem_rd=0, pointer=0 and stall counters=0, independent of clk.
REQ-027 Reset mid-access SHALL abandon the access without an ack; the first post-reset grant SHALL follow REQ-016.

Configuration
REQ-028 With PM_ARBITER_STATS_EN defined, stall_x SHALL increment each cycle hold_x is 1 and saturate at 16'hFFFF.
REQ-029 Without PM_ARBITER_STATS_EN, stall0/stall1 SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-030 Package pm_arbiter_pkg SHALL hold the state enum (IDLE/ACCESS/DONE) and the default ADDR_W, DATA_W and MEM_LAT constants.
REQ-031 The 2-way round-robin pick SHALL be the sub-module pm_arbiter_rr (inputs req0, req1, last; output grant).

Verification (MEM_LAT=4)
REQ-032 Single fetch: req0=1, addr0=8'h10 at edge 5; mem_rdata=8'hA5 -> mem_addr=8'h10 for 4 cycles; ack0 and rdata=8'hA5 at cycle 10.
REQ-033 Contention: req0 and req1 both rising together -> cache 0 served first, cache 1 second, hold1 high throughout; a second collision grants cache 1 first.
REQ-034 Late request: req1 rises during an ACCESS for cache 0 -> no preemption; cache 1 granted in the IDLE after ack0.
REQ-035 Abort: reset low in the 2nd ACCESS cycle -> no ack, hold_count=0, FSM in IDLE; a subsequent req0 completes normally.
REQ-036 Stats (macro on): a contended pair -> stall1 = 11 (5 + 1 IDLE + 5); macro off -> stall1 = 0.
REQ-037 Req drop: req0 falls after 2 ACCESS cycles -> ack0 still pulses, and the next grant is to cache 1 if it is requesting.
